// File: rtl/cnn_pkg.sv
// Shared types and address helpers for the CNN datapath blocks.
package cnn_pkg;

   // Channel streamer sequencing states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_HOLD = 3'd1,
      ST_PRIME0    = 3'd2,
      ST_PRIME1    = 3'd3,
      ST_STREAM    = 3'd4,
      ST_SWITCH    = 3'd5,
      ST_DONE      = 3'd6
   } strm_state_e;

   // Pixels per channel plane
   function automatic int unsigned npix(input int unsigned rows, input int unsigned cols);
      return rows * cols;
   endfunction

   // Address of pixel 0 of channel c (planes stored back to back)
   function automatic int unsigned chan_base(input int unsigned base, input int unsigned c,
                                             input int unsigned n_pix);
      return base + c * n_pix;
   endfunction

endpackage

// File: rtl/rr_channel_select.sv
// Round-robin pick of the next non-exhausted channel after the active one.
module rr_channel_select #(
   parameter int unsigned N_CHANNELS = 3,
   parameter int unsigned CH_W       = 2
) (
   input  logic [CH_W-1:0]       ch_i,
   input  logic [N_CHANNELS-1:0] exhausted_i,
   output logic [CH_W-1:0]       next_ch_o,
   output logic                  all_done_o
);

   int unsigned idx;
   logic        found;

   // Scan ch+1, ch+2, ... wrapping, ending on ch itself
   always_comb begin
      next_ch_o = ch_i;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned i = 1; i <= N_CHANNELS; i++) begin
         idx = (32'(ch_i) + i) % N_CHANNELS;
         if (!found && !exhausted_i[CH_W'(idx)]) begin
            next_ch_o = CH_W'(idx);
            found     = 1'b1;
         end
      end
      all_done_o = &exhausted_i;
   end

endmodule

// File: rtl/image_channel_streamer.sv
// Streams a multi-channel image from a 1-cycle-latency RAM into the first conv
// core, one channel at a time, rotating channels whenever the core holds off.
module image_channel_streamer
   import cnn_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned N_ROWS     = 28,
   parameter int unsigned N_COLS     = 28,
   parameter int unsigned N_CHANNELS = 3,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                                  clock_i,
   input  logic                                  reset_ni,
   input  logic                                  enable_i,
   input  logic                                  start_i,
   output logic [ADDR_WIDTH-1:0]                 ram_rdaddress_o,
   input  logic [DATA_WIDTH-1:0]                 ram_data_i,
   input  logic [N_CHANNELS-1:0]                 hold_data_i,
   output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] data_o,
   output logic [N_CHANNELS-1:0]                 data_valid_o,
   output logic                                  busy_o,
   output logic                                  done_o
);

   localparam int unsigned NPIX  = npix(N_ROWS, N_COLS);
   localparam int unsigned CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int unsigned PTR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NPIX - 1);
   localparam longint unsigned END_ADDR = 64'(BASE_ADDR) + 64'(N_CHANNELS) * 64'(NPIX);

   // The whole image must fit in the RAM address space
   if (END_ADDR >= (64'd1 << ADDR_WIDTH)) begin : g_addr_range_err
      $error("image_channel_streamer: image does not fit in ADDR_WIDTH address space");
   end

   strm_state_e                          state_q;
   logic [CH_W-1:0]                      ch_q;
   logic [N_CHANNELS-1:0][PTR_W-1:0]     ptr_q;
   logic [N_CHANNELS-1:0]                exh_q;
   logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] data_q;
   logic [N_CHANNELS-1:0]                valid_q;
   logic                                 busy_q;
   logic                                 done_q;
   logic [ADDR_WIDTH-1:0]                addr_q;

   logic [ADDR_WIDTH-1:0] chbase;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [PTR_W-1:0]      cur_ptr;
   logic                  xfer;
   logic [CH_W-1:0]       next_ch;
   logic                  all_done;

   assign cur_ptr = ptr_q[ch_q];
   assign chbase  = ADDR_WIDTH'(chan_base(BASE_ADDR, 32'(ch_q), NPIX));
   assign xfer    = (state_q == ST_STREAM) && valid_q[ch_q] && !hold_data_i[ch_q];

   rr_channel_select #(
      .N_CHANNELS (N_CHANNELS),
      .CH_W       (CH_W)
   ) u_rr_sel (
      .ch_i        (ch_q),
      .exhausted_i (exh_q),
      .next_ch_o   (next_ch),
      .all_done_o  (all_done)
   );

   // Read address: one word ahead of data_o while streaming, two on a transfer
   always_comb begin
      addr_d = chbase + ADDR_WIDTH'(cur_ptr);
      case (state_q)
         ST_PRIME1: addr_d = chbase + ADDR_WIDTH'(cur_ptr) + ADDR_WIDTH'(1);
         ST_STREAM: addr_d = chbase + ADDR_WIDTH'(cur_ptr) + ADDR_WIDTH'(1) + ADDR_WIDTH'(xfer);
         default:   ;
      endcase
   end

   // While disabled the RAM keeps seeing the last issued address
   assign ram_rdaddress_o = enable_i ? addr_d : addr_q;

   // Sequencer, per-channel pointers and registered outputs
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         ptr_q   <= '0;
         exh_q   <= '0;
         data_q  <= '0;
         valid_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
      end else if (enable_i) begin
         addr_q <= addr_d;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_q <= ST_WAIT_HOLD;
                  ch_q    <= '0;
                  ptr_q   <= '0;
                  exh_q   <= '0;
                  valid_q <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ST_WAIT_HOLD: begin
               if (!hold_data_i[ch_q]) state_q <= ST_PRIME0;
            end
            ST_PRIME0: state_q <= ST_PRIME1;
            ST_PRIME1: begin
               data_q[ch_q]  <= ram_data_i;
               valid_q[ch_q] <= 1'b1;
               state_q       <= ST_STREAM;
            end
            ST_STREAM: begin
               if (xfer) begin
                  if (cur_ptr != PTR_LAST) begin
                     data_q[ch_q] <= ram_data_i;
                     ptr_q[ch_q]  <= cur_ptr + PTR_W'(1);
                  end else begin
                     exh_q[ch_q]   <= 1'b1;
                     valid_q[ch_q] <= 1'b0;
                     state_q       <= ST_SWITCH;
                  end
               end else begin
                  // Held word stays at ptr and is re-read when the channel returns
                  valid_q[ch_q] <= 1'b0;
                  state_q       <= ST_SWITCH;
               end
            end
            ST_SWITCH: begin
               if (all_done) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  ch_q    <= next_ch;
                  state_q <= ST_WAIT_HOLD;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_o       = data_q;
   assign data_valid_o = valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_image_channel_streamer.sv
// Scoreboard bench for image_channel_streamer: 4x4 image, 3 channels, word = address RAM.
module tb_image_channel_streamer;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned NR  = 4;
   localparam int unsigned NC  = 4;
   localparam int unsigned NCH = 3;
   localparam int unsigned NPX = NR * NC;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    enable = 1'b1;
   logic                    start = 1'b0;
   logic [NCH-1:0]          hold = '0;
   logic [AW-1:0]           addr;
   logic [DW-1:0]           ram_q;
   logic [NCH-1:0][DW-1:0]  data;
   logic [NCH-1:0]          valid;
   logic                    busy;
   logic                    done;

   int total = 0;
   int bad   = 0;
   int xc [NCH];
   int mode = 0;
   int cyc = 0;
   int last_c = -1;
   int last_cyc = 0;
   bit ord_en = 1'b0;

   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [31:0] q2 [$];
   logic [31:0] ord [$];

   image_channel_streamer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .N_ROWS     (NR),
      .N_COLS     (NC),
      .N_CHANNELS (NCH),
      .BASE_ADDR  (0)
   ) dut (
      .clock_i         (clk),
      .reset_ni        (rst_n),
      .enable_i        (enable),
      .start_i         (start),
      .ram_rdaddress_o (addr),
      .ram_data_i      (ram_q),
      .hold_data_i     (hold),
      .data_o          (data),
      .data_valid_o    (valid),
      .busy_o          (busy),
      .done_o          (done)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, 1-cycle latency, contents equal to address
   always @(posedge clk) ram_q <= DW'(addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Consumer: pop expected words on every transfer
   always @(negedge clk) begin : mon
      logic [31:0] e;
      int          sz;
      cyc++;
      if (rst_n && enable && (valid != '0)) begin
         chk("onehot", 32'($countones(valid)), 32'd1);
         for (int c = 0; c < NCH; c++) begin
            if (valid[c] && !hold[c]) begin
               e  = '0;
               sz = 0;
               case (c)
                  0: begin sz = q0.size(); if (sz != 0) e = q0.pop_front(); end
                  1: begin sz = q1.size(); if (sz != 0) e = q1.pop_front(); end
                  2: begin sz = q2.size(); if (sz != 0) e = q2.pop_front(); end
                  default: sz = 0;
               endcase
               if (sz == 0) chk("sb_extra_word", data[c], 32'hFFFF_FFFF);
               else         chk("word", data[c], e);
               if (ord_en) begin
                  if (ord.size() == 0) chk("ord_extra_word", data[c], 32'hFFFF_FFFF);
                  else                 chk("order", data[c], ord.pop_front());
               end
               if (mode == 1 && last_c == c) chk("gap", 32'(cyc - last_cyc), 32'd1);
               last_c   = c;
               last_cyc = cyc;
               xc[c]++;
            end
         end
      end
   end

   task automatic sb_load();
      q0.delete(); q1.delete(); q2.delete(); ord.delete();
      for (int p = 0; p < NPX; p++) begin
         q0.push_back(32'(p));
         q1.push_back(32'(NPX + p));
         q2.push_back(32'(2 * NPX + p));
      end
      for (int c = 0; c < NCH; c++) xc[c] = 0;
      last_c = -1;
   endtask

   task automatic ord_push(input int lo, input int hi);
      for (int w = lo; w <= hi; w++) ord.push_back(32'(w));
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run(input int m);
      bit t1 = 1'b0;
      bit r1 = 1'b0;
      bit t2 = 1'b0;
      int hc = 0;
      int fc = 0;
      mode = m;
      for (int budget = 0; budget < 3000; budget++) begin
         @(posedge clk); #1;
         if (done) break;
         case (m)
            1: begin
               hold = '0;
               if (!t1 && xc[0] == 8) begin start = 1'b1; t1 = 1'b1; end
               else start = 1'b0;
            end
            2: begin
               if (!t1 && xc[0] == 6) begin hold[0] = 1'b1; t1 = 1'b1; end
               if (t1 && !r1 && valid[1]) begin hold[0] = 1'b0; r1 = 1'b1; end
            end
            3: begin
               for (int c = 0; c < NCH; c++) hold[c] = ($urandom_range(0, 99) < 30);
            end
            4: begin
               if (!t1 && xc[0] == 3) begin hold[0] = 1'b1; t1 = 1'b1; end
               if (t1 && !r1 && valid[1]) begin hold[0] = 1'b0; r1 = 1'b1; end
               if (r1 && !t2 && xc[0] == 10 && xc[1] == 16 && xc[2] == 16) begin
                  hold[0] = 1'b1; t2 = 1'b1; hc = 0;
               end else if (t2 && hold[0]) begin
                  hc++;
                  if (hc == 4) hold[0] = 1'b0;
               end
            end
            5: begin
               if (!t1 && xc[0] == 5) begin enable = 1'b0; t1 = 1'b1; fc = 0; end
               else if (t1 && !enable) begin
                  fc++;
                  if (fc == 5) enable = 1'b1;
               end
               if (!enable) begin
                  #1;
                  chk("frz_data", data[0], 32'd5);
                  chk("frz_valid", 32'(valid), 32'd1);
                  chk("frz_addr", 32'(addr), 32'd6);
               end
            end
            6: begin
               if (!t1 && xc[0] == 7) begin
                  #2 rst_n = 1'b0;
                  #1;
                  chk("rst_valid", 32'(valid), 32'd0);
                  for (int c = 0; c < NCH; c++) chk("rst_data", data[c], 32'd0);
                  chk("rst_busy", 32'(busy), 32'd0);
                  chk("rst_done", 32'(done), 32'd0);
                  chk("rst_addr", 32'(addr), 32'd0);
                  t1 = 1'b1;
                  break;
               end
            end
            default: ;
         endcase
      end
      if (m != 6) begin
         chk("done", 32'(done), 32'd1);
         chk("busy_end", 32'(busy), 32'd0);
         chk("valid_end", 32'(valid), 32'd0);
         chk("sb_left", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
         if (ord_en) chk("ord_left", 32'(ord.size()), 32'd0);
      end
      hold   = '0;
      enable = 1'b1;
      start  = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_addr", 32'(addr), 32'd0);
      chk("reset_data0", data[0], 32'd0);
      rst_n = 1'b1;

      // Free-running stream, start pulse mid-frame must be ignored
      ord_en = 1'b1; sb_load(); ord_push(0, 47);
      pulse_start(); run(1);

      // Hold on ch0 with word 6 pending
      sb_load(); ord_push(0, 5); ord_push(16, 47); ord_push(6, 15);
      pulse_start(); run(2);

      // Random back-pressure
      ord_en = 1'b0; sb_load();
      pulse_start(); run(3);

      // Last remaining channel holds and is re-primed
      ord_en = 1'b1; sb_load(); ord_push(0, 2); ord_push(16, 47); ord_push(3, 15);
      pulse_start(); run(4);

      // Enable freeze mid-stream
      sb_load(); ord_push(0, 47);
      pulse_start(); run(5);

      // Reset mid-frame then replay from word 0
      ord_en = 1'b0; sb_load();
      pulse_start(); run(6);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ord_en = 1'b1; sb_load(); ord_push(0, 47);
      pulse_start(); run(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
